// File: rtl/ram_stream_reader_if.sv
// Signal bundle between ram_stream_reader, its controller, the simple_ram read port and the
// downstream stream consumer.
interface ram_stream_reader_if #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned WIDTHAD = 7
);
    logic               start;
    logic [WIDTHAD-1:0] base_addr;
    logic [WIDTHAD:0]   len;
    logic               busy;
    logic               done;
    logic [WIDTHAD-1:0] rd_addr;
    logic [WIDTH-1:0]   ram_q;
    logic [WIDTH-1:0]   m_data;
    logic               m_valid;
    logic               m_last;
    logic               m_ready;

    modport master (
        input  start, base_addr, len, ram_q, m_ready,
        output busy, done, rd_addr, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, len, ram_q, m_ready,
        input  busy, done, rd_addr, m_data, m_valid, m_last
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams len consecutive words from a registered-read RAM starting at base_addr, with a
// 2-entry output buffer so a stalled consumer never loses data.
module ram_stream_reader #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned WIDTHAD = 7
) (
    input logic                 clk,
    input logic                 rst,
    ram_stream_reader_if.master bus
);
    localparam int unsigned CntW = WIDTHAD + 1;

    typedef logic [WIDTHAD-1:0] addr_t;
    typedef logic [CntW-1:0]    cnt_t;
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    cnt_t             len_q, len_d;
    cnt_t             issue_cnt_q, issue_cnt_d;
    cnt_t             beat_cnt_q, beat_cnt_d;
    addr_t            rd_addr_q, rd_addr_d;
    logic             addr_pend_q, addr_pend_d;  // rd_addr just moved, ram_q not yet valid
    logic             q_pend_q, q_pend_d;        // ram_q holds a word not yet captured
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;

    logic       accept, issue_start, issue_run, issue, push, pop, last_beat;
    logic [2:0] slots;

    assign accept      = (state_q == StIdle) && bus.start;
    assign issue_start = accept && (bus.len != '0);
    assign pop         = bus.m_valid && bus.m_ready;
    // The RAM output register holds its word while rd_addr is unchanged, so it serves as a
    // third slot; capping committed words at 3 keeps the 2-entry buffer from overflowing.
    assign slots       = {1'b0, occ_q} + {2'b0, addr_pend_q} + {2'b0, q_pend_q} - {2'b0, pop};
    assign issue_run   = (state_q == StRun) && (issue_cnt_q < len_q) && (slots < 3'd3);
    assign issue       = issue_start || issue_run;
    assign push        = q_pend_q && ((occ_q != 2'd2) || pop);
    assign last_beat   = pop && bus.m_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            rd_addr_q   <= '0;
            addr_pend_q <= 1'b0;
            q_pend_q    <= 1'b0;
            buf_q       <= '{default: '0};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_addr_q   <= rd_addr_d;
            addr_pend_q <= addr_pend_d;
            q_pend_q    <= q_pend_d;
            buf_q       <= buf_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = (bus.len == '0) ? StDone : StRun;
            StRun:   if (last_beat) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        len_d       = accept ? bus.len : len_q;
        issue_cnt_d = accept ? '0 : issue_cnt_q;
        if (issue) issue_cnt_d = issue_cnt_d + cnt_t'(1);
        beat_cnt_d  = accept ? '0 : beat_cnt_q + cnt_t'(pop);

        rd_addr_d = rd_addr_q;
        if (issue_start)    rd_addr_d = bus.base_addr;
        else if (issue_run) rd_addr_d = rd_addr_q + addr_t'(1);

        addr_pend_d = issue;
        q_pend_d    = addr_pend_q || (q_pend_q && !push);

        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            buf_d[wr_ptr_q] = bus.ram_q;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        bus.busy    = (state_q != StIdle);
        bus.done    = (state_q == StDone);
        bus.rd_addr = rd_addr_q;
        bus.m_data  = buf_q[rd_ptr_q];
        bus.m_valid = (occ_q != 2'd0);
        // Last is tracked by beat count so a wrapped address range cannot confuse it.
        bus.m_last  = bus.m_valid && (beat_cnt_q == len_q - cnt_t'(1));
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed plus randomized bench for ram_stream_reader against a registered-read RAM model;
// expected beats are computed as mem[(base + k) mod 2**WIDTHAD].
module tb_ram_stream_reader;
    localparam int unsigned WIDTH   = 64;
    localparam int unsigned WIDTHAD = 7;
    localparam int unsigned Words   = 1 << WIDTHAD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_stream_reader_if #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) bus ();

    ram_stream_reader #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [Words];
    always @(posedge clk) bus.ram_q <= mem[bus.rd_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // m_ready driver: 0 = always high, 1 = fixed pattern 1,0,0,1,0,1, 2 = random
    int         ready_mode = 0;
    int         pidx       = 0;
    logic [5:0] pat        = 6'b101001;
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.m_ready = pat[pidx % 6];
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b1;
            endcase
            pidx++;
        end
    end

    // Beat collector and stall-stability monitor
    logic [WIDTH-1:0] beat_q [$];
    logic             last_q [$];
    int               first_pop_cyc = 0;
    int               last_pop_cyc  = 0;
    int               done_cyc      = 0;
    int               done_cnt      = 0;
    logic             stall_prev    = 1'b0;
    logic [WIDTH-1:0] prev_data     = '0;
    always @(negedge clk) begin
        if (!rst && stall_prev) begin
            chk("hold_valid", 64'(bus.m_valid), 64'd1);
            chk("hold_data", bus.m_data, prev_data);
        end
        if (!rst && bus.m_valid && bus.m_ready) begin
            beat_q.push_back(bus.m_data);
            last_q.push_back(bus.m_last);
            if (beat_q.size() == 1) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (!rst && bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        stall_prev = !rst && bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
    end

    task automatic run_xfer(input int b, input int l, input int mode, input bit poke);
        int n;
        int d0;
        int t;
        int budget;
        ready_mode = mode;
        beat_q.delete();
        last_q.delete();
        d0 = done_cnt;
        bus.start     = 1'b1;
        bus.base_addr = WIDTHAD'(b);
        bus.len       = (WIDTHAD + 1)'(l);
        tick();
        n = cyc - 1;
        bus.start     = 1'b0;
        bus.base_addr = WIDTHAD'($urandom);
        bus.len       = (WIDTHAD + 1)'($urandom_range(1, Words));
        if (l != 0) chk("rd_addr_first", 64'(bus.rd_addr), 64'(b % Words));
        budget = 8 * l + 50;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            bus.start = poke && (t == 2);
            tick();
            t++;
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("beat_count", 64'(beat_q.size()), 64'(l));
        for (int k = 0; k < beat_q.size() && k < l; k++) begin
            chk("data", beat_q[k], mem[(b + k) % Words]);
            chk("last", 64'(last_q[k]), 64'(k == l - 1));
        end
        if (l == 0) begin
            chk("done_cyc_len0", 64'(done_cyc), 64'(n + 1));
        end else begin
            chk("done_after_last", 64'(done_cyc), 64'(last_pop_cyc + 1));
            if (mode == 0) begin
                chk("first_beat_cyc", 64'(first_pop_cyc), 64'(n + 3));
                chk("done_cyc", 64'(done_cyc), 64'(n + 3 + l));
            end
        end
        tick();
        chk("done_once", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        int t;
        for (int i = 0; i < int'(Words); i++) mem[i] = {32'($urandom), 32'(i)};
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_last", 64'(bus.m_last), 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst_data", bus.m_data, 64'd0);
        rst = 1'b0;
        tick();

        run_xfer(32'h10, 4, 0, 1'b0);
        run_xfer(32'h10, 4, 1, 1'b0);
        run_xfer(32'h7E, 4, 0, 1'b0);
        run_xfer(0, 0, 0, 1'b0);
        run_xfer(32'h40, int'(Words), 0, 1'b0);
        run_xfer(32'h20, 12, 0, 1'b1);
        run_xfer(32'h05, int'(Words), 2, 1'b0);

        // Reset in the middle of an 8-beat transfer
        ready_mode = 0;
        beat_q.delete();
        bus.start     = 1'b1;
        bus.base_addr = WIDTHAD'(32'h30);
        bus.len       = (WIDTHAD + 1)'(8);
        tick();
        bus.start = 1'b0;
        t = 0;
        while (beat_q.size() < 2 && t < 40) begin
            tick();
            t++;
        end
        chk("mid_two_beats", 64'(beat_q.size() >= 2), 64'd1);
        rst = 1'b1;
        d0  = done_cnt;
        tick();
        chk("mid_rst_valid", 64'(bus.m_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("mid_rst_data", bus.m_data, 64'd0);
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        run_xfer(32'h55, 8, 2, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_xfer(int'($urandom_range(0, Words - 1)), int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
